// File: rtl/dpram_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dpram_rd_ctrl
// Description : Read side of a dual-port-RAM FIFO. Issues credit-limited RAM
//               reads and streams the returned words through a 4-entry skid
//               FIFO. Define DPRAM_RD_OUTPUT_REG_EN for a RAM with its output
//               register enabled (two-edge read latency instead of one).
// Revision    : 1.0 - initial release
// ============================================================================
module dpram_rd_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  ovf_err
);

`ifdef DPRAM_RD_OUTPUT_REG_EN
    localparam int c_lat = 2;
`else
    localparam int c_lat = 1;
`endif
    localparam int c_depth = 4;
    localparam logic [ADDR_WIDTH:0] c_span = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [c_lat-1:0]      tag_q, tag_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [1:0]            wr_idx_q, wr_idx_d;
    logic [1:0]            rd_idx_q, rd_idx_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mem_q [c_depth];

    logic [ADDR_WIDTH:0]   w_level;
    logic [2:0]            w_inflight;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;

    assign w_level = wr_ptr - rd_ptr_q;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < c_lat; i++) begin
            w_inflight = w_inflight + 3'(tag_q[i]);
        end
    end

    // Credits cover both buffered words and words still inside the RAM pipe,
    // so a capture can never find the FIFO full.
    assign w_issue = (w_level != '0) && !flush &&
                     (({1'b0, cnt_q} + {1'b0, w_inflight}) < 4'(c_depth));
    assign w_push  = tag_q[c_lat-1] & ~flush;
    assign w_pop   = m_valid & m_ready & ~flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        ovf_d    = ovf_q;
        if (flush) begin
            rd_ptr_d = wr_ptr;
            tag_d    = '0;
            cnt_d    = '0;
            wr_idx_d = '0;
            rd_idx_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (w_issue) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            for (int i = c_lat - 1; i > 0; i--) begin
                tag_d[i] = tag_q[i-1];
            end
            tag_d[0] = w_issue;
            if (w_push) begin
                wr_idx_d = wr_idx_q + 2'd1;
            end
            if (w_pop) begin
                rd_idx_d = rd_idx_q + 2'd1;
            end
            cnt_d = cnt_q + 3'(w_push) - 3'(w_pop);
            if (w_level > c_span) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_ptr_q <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < c_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            ovf_q    <= ovf_d;
            if (w_push) begin
                mem_q[wr_idx_q] <= rd_data;
            end
        end
    end

    assign rd_ptr  = rd_ptr_q;
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign level   = w_level;
    assign empty   = (w_level == '0);
    assign m_valid = (cnt_q != '0);
    assign m_data  = mem_q[rd_idx_q];
    assign ovf_err = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dpram_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_rd_ctrl
// Description : Self-checking bench for dpram_rd_ctrl with a synchronous RAM
//               model and a queue-based expected-stream reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_rd_ctrl;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int PW = AW + 1;
    localparam int NWORDS = 1 << AW;
`ifdef DPRAM_RD_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          rd_clk   = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic          flush    = 1'b0;
    logic          m_ready  = 1'b0;
    logic [AW:0]   wr_ptr   = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic [AW:0]   level;
    logic          empty;
    logic          ovf_err;

    logic [DW-1:0] ram [NWORDS];
    logic [DW-1:0] ram_q1, ram_q2;
    logic [DW-1:0] exp_q [$];
    int            total = 0;
    int            bad = 0;
    bit            beat_flag;

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) begin
        ram_q1 <= ram[rd_addr];
        ram_q2 <= ram_q1;
    end
`ifdef DPRAM_RD_OUTPUT_REG_EN
    assign rd_data = ram_q2;
`else
    assign rd_data = ram_q1;
`endif

    dpram_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .rd_clk  (rd_clk),
        .rd_rst_n(rd_rst_n),
        .wr_ptr  (wr_ptr),
        .flush   (flush),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_ptr  (rd_ptr),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level),
        .empty   (empty),
        .ovf_err (ovf_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: a transfer that will happen at the coming edge is checked
    // against the head of the expected stream at the preceding falling edge.
    task automatic tick();
        beat_flag = 1'b0;
        @(negedge rd_clk);
        if (rd_rst_n && !flush && m_ready && m_valid === 1'b1) begin
            beat_flag = 1'b1;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL stale_beat observed=0x%0h expected=no beat", m_data);
            end
            if (exp_q.size() != 0) begin
                chk("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
        @(posedge rd_clk);
        #1;
    endtask

    // Advancing the writer pointer appends the newly written words, in
    // pointer order, to the expected stream.
    task automatic set_wr(input logic [AW:0] nw);
        logic [AW:0] p;
        p = wr_ptr;
        while (p != nw) begin
            exp_q.push_back(ram[p[AW-1:0]]);
            p = p + 1'b1;
        end
        wr_ptr = nw;
    endtask

    task automatic do_flush(input logic [AW:0] nw);
        flush  = 1'b1;
        wr_ptr = nw;
        exp_q.delete();
        tick();
        flush = 1'b0;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int k = 0; k < 300 && (exp_q.size() != 0 || m_valid); k++) begin
            tick();
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n, first, last;
        logic [DW-1:0] hold;
        logic [AW:0] base;

        for (int i = 0; i < NWORDS; i++) ram[i] = 16'(32'hFFFF - i);

        // Reset state
        repeat (3) @(posedge rd_clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        rd_rst_n = 1'b1;
        tick();

        // First-beat latency and four back-to-back beats
        m_ready = 1'b1;
        set_wr(PW'(4));
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            chk($sformatf("first_valid_e%0d", k), 32'(m_valid), 32'(k == LAT + 1));
        end
        n = 0; first = -1; last = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (beat_flag) begin
                if (first < 0) first = k;
                last = k;
                n++;
            end
        end
        chk("s2_beats", 32'(n), 32'd4);
        chk("s2_contig", 32'(last - first + 1), 32'd4);
        chk("s2_rd_ptr", 32'(rd_ptr), 32'd4);
        chk("s2_empty", 32'(empty), 32'd1);

        // Backpressure: credit limit and held data, then sustained drain
        m_ready = 1'b0;
        set_wr(PW'(16));
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) hold = m_data;
            else if (k > 3) chk("stall_data_steady", 32'(m_data), 32'(hold));
        end
        chk("stall_rd_ptr", 32'(rd_ptr), 32'd8);
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_head", 32'(m_data), 32'(exp_q[0]));
        m_ready = 1'b1;
        n = 0; first = -1; last = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (beat_flag) begin
                if (first < 0) first = k;
                last = k;
                n++;
            end
        end
        chk("s3_beats", 32'(n), 32'd12);
        chk("s3_contig", 32'(last - first + 1), 32'd12);
        chk("s3_rd_ptr", 32'(rd_ptr), 32'd16);

        // Address wrap
        do_flush(PW'(11'h3FE));
        chk("wrap_start_ptr", 32'(rd_ptr), 32'h3FE);
        chk("wrap_start_valid", 32'(m_valid), 32'd0);
        set_wr(PW'(11'h402));
        #1;
        chk("wrap_level4", 32'(level), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wrap_addr%0d", k), 32'(rd_addr), 32'((32'h3FE + k) % NWORDS));
            tick();
        end
        drain();
        chk("wrap_rd_ptr", 32'(rd_ptr), 32'h402);
        chk("wrap_level0", 32'(level), 32'd0);

        // Flush with words buffered and in flight
        m_ready = 1'b0;
        set_wr(PW'(11'h40A));
        repeat (3) tick();
        chk("pre_flush_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        do_flush(PW'(11'h40A));
        chk("flush_valid", 32'(m_valid), 32'd0);
        chk("flush_rd_ptr", 32'(rd_ptr), 32'h40A);
        chk("flush_empty", 32'(empty), 32'd1);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (beat_flag) n++;
        end
        chk("flush_no_stale", 32'(n), 32'd0);

        // Overrun boundary: exactly 2^AW unread is not an overrun
        m_ready = 1'b0;
        base = rd_ptr;
        wr_ptr = base + PW'(11'h400);
        tick();
        chk("ovf_at_limit", 32'(ovf_err), 32'd0);
        do_flush(wr_ptr);
        base = rd_ptr;
        wr_ptr = base + PW'(11'h401);
        tick();
        chk("ovf_set", 32'(ovf_err), 32'd1);
        repeat (6) tick();
        chk("ovf_sticky", 32'(ovf_err), 32'd1);
        chk("ovf_reads_go_on", 32'(rd_ptr), 32'(PW'(base + PW'(4))));
        do_flush(wr_ptr);
        chk("ovf_cleared", 32'(ovf_err), 32'd0);
        chk("ovf_flush_level", 32'(level), 32'd0);

        // Randomised traffic against the expected-stream model
        for (int i = 0; i < NWORDS; i++) ram[i] = 16'($urandom);
        for (int c = 0; c < 400; c++) begin
            m_ready = (($urandom % 4) != 0);
            if (($urandom % 3) == 0 && exp_q.size() < 40)
                set_wr(PW'(wr_ptr + PW'($urandom_range(1, 6))));
            if (($urandom % 97) == 0) do_flush(PW'(wr_ptr + PW'($urandom_range(0, 3))));
            else tick();
        end
        drain();
        chk("rand_rd_ptr", 32'(rd_ptr), 32'(wr_ptr));

        // Reset in mid-transfer discards everything
        set_wr(PW'(wr_ptr + PW'(8)));
        repeat (LAT + 2) tick();
        #2 rd_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_data", 32'(m_data), 32'd0);
        chk("mid_rst_rd_ptr", 32'(rd_ptr), 32'd0);
        wr_ptr = '0;
        exp_q.delete();
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (beat_flag) n++;
        end
        chk("post_rst_beats", 32'(n), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
